// File: rtl/ddr_rd_pixel_unpack_if.sv
// Handshake bundle between the DDR prefetch FIFO / timing generator and the
// RGB565 pixel unpacker.
interface ddr_rd_pixel_unpack_if;
    logic        vs_in;
    logic        pix_req;
    logic        fifo_rd_en;
    logic        fifo_rd_vld;
    logic [31:0] fifo_rd_data;
    logic [15:0] pix_data;
    logic        pix_vld;
    logic        line_end;
    logic        frame_end;
    logic        resync_req;
    logic        underflow;
    logic [15:0] underflow_cnt;

    modport slave (
        input  vs_in, pix_req, fifo_rd_vld, fifo_rd_data,
        output fifo_rd_en, pix_data, pix_vld, line_end, frame_end,
               resync_req, underflow, underflow_cnt
    );

    modport master (
        output vs_in, pix_req, fifo_rd_vld, fifo_rd_data,
        input  fifo_rd_en, pix_data, pix_vld, line_end, frame_end,
               resync_req, underflow, underflow_cnt
    );
endinterface

// File: rtl/ddr_rd_pixel_unpack.sv
// Pops 32-bit words from the DDR prefetch FIFO and streams them out as RGB565
// pixels on demand; underflow fills the frame. UNPACK_UNDERFLOW_CNT_EN adds the slot counter.
module ddr_rd_pixel_unpack #(
    parameter int          H_ACT      = 1024,
    parameter int          V_ACT      = 768,
    parameter logic [15:0] FILL_COLOR = 16'h0000
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    ddr_rd_pixel_unpack_if.slave  bus
);
    localparam int XW = $clog2(H_ACT);
    localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

    typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, ERR} state_t;

    state_t        state;
    logic [31:0]   hold;
    logic          hold_vld;
    logic          half;
    logic          err_pending;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    logic slot, serve, starve, fill, pop, x_last, f_last;

    always_comb begin
        slot   = bus.pix_req & ~bus.vs_in & (state != IDLE);
        serve  = slot & (state == ACTIVE) & hold_vld;
        starve = slot & ((state == PRIME) | ((state == ACTIVE) & ~hold_vld));
        fill   = starve | (slot & (state == ERR));
        x_last = (x == X_LAST);
        f_last = x_last & (y == Y_LAST);
        // A word popped alongside vs_in would be dropped by the abort, so don't take it.
        bus.fifo_rd_en = ~rd_rst & ~bus.vs_in & bus.fifo_rd_vld
                       & ((state == PRIME) | (state == ACTIVE))
                       & (~hold_vld | (bus.pix_req & half & (state == ACTIVE)));
        pop = bus.fifo_rd_en;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state          <= IDLE;
            hold           <= '0;
            hold_vld       <= 1'b0;
            half           <= 1'b0;
            err_pending    <= 1'b0;
            x              <= '0;
            y              <= '0;
            bus.pix_data   <= '0;
            bus.pix_vld    <= 1'b0;
            bus.line_end   <= 1'b0;
            bus.frame_end  <= 1'b0;
            bus.resync_req <= 1'b0;
            bus.underflow  <= 1'b0;
        end else begin
            bus.pix_data   <= '0;
            bus.pix_vld    <= 1'b0;
            bus.line_end   <= 1'b0;
            bus.frame_end  <= 1'b0;
            bus.resync_req <= 1'b0;

            if (pop) begin
                hold     <= bus.fifo_rd_data;
                hold_vld <= 1'b1;
            end else if (serve & half) begin
                hold_vld <= 1'b0;
            end

            if (state == IDLE) begin
                if (bus.vs_in) begin
                    state <= PRIME;
                    if (err_pending) begin
                        bus.resync_req <= 1'b1;
                        hold_vld       <= 1'b0;
                        err_pending    <= 1'b0;
                    end
                end
            end else if (bus.vs_in) begin
                // Early frame start: throw away the partial frame and ask upstream to restart.
                state          <= PRIME;
                x              <= '0;
                y              <= '0;
                half           <= 1'b0;
                hold_vld       <= 1'b0;
                bus.resync_req <= 1'b1;
            end else if ((state == PRIME) & hold_vld & ~bus.pix_req) begin
                state <= ACTIVE;
            end

            if (slot) begin
                bus.pix_vld  <= 1'b1;
                bus.pix_data <= fill ? FILL_COLOR : (half ? hold[31:16] : hold[15:0]);
                if (serve) half <= ~half;
                if (starve) begin
                    state         <= ERR;
                    bus.underflow <= 1'b1;
                end
                if (x_last) begin
                    bus.line_end <= 1'b1;
                    x            <= '0;
                    y            <= f_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
                if (f_last) begin
                    bus.frame_end <= 1'b1;
                    half          <= 1'b0;
                    state         <= IDLE;
                    err_pending   <= fill;
                end
            end
        end
    end

`ifdef UNPACK_UNDERFLOW_CNT_EN
    logic [15:0] ucnt;
    always_ff @(posedge rd_clk) begin
        if (rd_rst)                      ucnt <= '0;
        else if (fill && ucnt != 16'hFFFF) ucnt <= ucnt + 16'd1;
    end
    assign bus.underflow_cnt = ucnt;
`else
    assign bus.underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_rd_pixel_unpack.sv
// Scoreboard bench for ddr_rd_pixel_unpack: small FIFO model, expected pixels
// queued at request time and compared when pix_vld comes back.
module tb_ddr_rd_pixel_unpack;
    localparam int          H = 8;
    localparam int          V = 2;
    localparam logic [15:0] FILL = 16'hF81F;

    typedef struct {
        logic [15:0] d;
        logic        le;
        logic        fe;
    } exp_t;

    logic clk, rst;
    ddr_rd_pixel_unpack_if bus();

    ddr_rd_pixel_unpack #(.H_ACT(H), .V_ACT(V), .FILL_COLOR(FILL)) dut (
        .rd_clk(clk),
        .rd_rst(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];

    int mx, my, mpix, fill_from, pops, served;
    bit m_run, m_errp, m_fillframe;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic load(input int n);
        for (int k = 0; k < n; k++) fifo_q.push_back({16'(2*k+1), 16'(2*k)});
    endtask

    // One clock: drive at +1 after the edge, sample at +1 after the next edge.
    task automatic cyc(input bit req, input bit vs);
        exp_t e;
        bit   slot, rs_exp, popped;
        bus.pix_req      = req;
        bus.vs_in        = vs;
        bus.fifo_rd_vld  = (fifo_q.size() != 0);
        bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        slot   = req & !vs & m_run;
        rs_exp = vs & (m_run | m_errp);
        if (vs) begin
            m_run = 1; m_errp = 0; m_fillframe = 0;
            mx = 0; my = 0; mpix = 0; pops = 0; served = 0;
        end
        if (slot) begin
            e.d  = (mpix >= fill_from) ? FILL : 16'(mpix);
            e.le = (mx == H - 1);
            e.fe = e.le && (my == V - 1);
            if (mpix >= fill_from) m_fillframe = 1;
            exp_q.push_back(e);
            mpix++;
            if (e.le) begin mx = 0; my++; end else mx++;
            if (e.fe) begin m_run = 0; m_errp = m_fillframe; my = 0; end
        end
        #1;
        chk("en_without_vld", {31'd0, bus.fifo_rd_en & ~bus.fifo_rd_vld}, 32'd0);
        popped = bus.fifo_rd_en;
        @(posedge clk);
        if (popped) begin void'(fifo_q.pop_front()); pops++; end
        #1;
        chk("pix_vld", {31'd0, bus.pix_vld}, {31'd0, slot});
        if (bus.pix_vld) begin
            served++;
            if (exp_q.size() == 0) begin
                chk("sb_underrun", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("pix_data",  {16'd0, bus.pix_data}, {16'd0, e.d});
                chk("line_end",  {31'd0, bus.line_end}, {31'd0, e.le});
                chk("frame_end", {31'd0, bus.frame_end}, {31'd0, e.fe});
            end
        end
        chk("resync_req", {31'd0, bus.resync_req}, {31'd0, rs_exp});
        // At most one word fetched ahead of the pixels already delivered.
        chk("prefetch_depth", {31'd0, pops <= served / 2 + 1}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pix_data"},   {16'd0, bus.pix_data}, 32'd0);
        chk({tag, "_pix_vld"},    {31'd0, bus.pix_vld}, 32'd0);
        chk({tag, "_line_end"},   {31'd0, bus.line_end}, 32'd0);
        chk({tag, "_frame_end"},  {31'd0, bus.frame_end}, 32'd0);
        chk({tag, "_resync_req"}, {31'd0, bus.resync_req}, 32'd0);
        chk({tag, "_underflow"},  {31'd0, bus.underflow}, 32'd0);
        chk({tag, "_ucnt"},       {16'd0, bus.underflow_cnt}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.vs_in = 0; bus.pix_req = 0; bus.fifo_rd_vld = 0; bus.fifo_rd_data = '0;
        mx = 0; my = 0; mpix = 0; pops = 0; served = 0; fill_from = 1000;
        m_run = 0; m_errp = 0; m_fillframe = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        rst = 1'b0;

        // Continuous requests
        load(8); cyc(0, 1); idle(3);
        repeat (16) cyc(1, 0);
        cyc(1, 0); idle(1);
        chk("t1_pops", 32'(pops), 32'd8);

        // Sparse requests
        load(8); cyc(0, 1); idle(3);
        repeat (16) begin cyc(1, 0); idle(2); end
        chk("t2_pops", 32'(pops), 32'd8);

        // Early vs_in at pixel 5 of line 0
        load(8); cyc(0, 1); idle(3);
        repeat (5) cyc(1, 0);
        fifo_q.delete(); load(8);
        cyc(0, 1); idle(3);
        repeat (16) cyc(1, 0);
        idle(1);
        chk("t4_underflow", {31'd0, bus.underflow}, 32'd0);

        // vs_in and pix_req together in ACTIVE
        load(8); cyc(0, 1); idle(3);
        repeat (2) cyc(1, 0);
        fifo_q.delete(); load(8);
        cyc(1, 1); idle(3);
        repeat (16) cyc(1, 0);
        idle(1);

        // Underflow: 2 words for an 8-word frame
        load(2); cyc(0, 1); idle(3);
        fill_from = 4;
        repeat (16) cyc(1, 0);
        idle(2);
        chk("t3_underflow", {31'd0, bus.underflow}, 32'd1);
`ifdef UNPACK_UNDERFLOW_CNT_EN
        chk("t3_ucnt", {16'd0, bus.underflow_cnt}, 32'd12);
`else
        chk("t3_ucnt", {16'd0, bus.underflow_cnt}, 32'd0);
`endif
        fill_from = 1000;
        load(8); cyc(0, 1); idle(1);
        idle(2);
        repeat (3) cyc(1, 0);

        // Reset mid-line with the FIFO offering a word
        rst = 1'b1;
        bus.pix_req = 1'b1; bus.vs_in = 1'b0;
        bus.fifo_rd_vld = 1'b1; bus.fifo_rd_data = fifo_q[0];
        #1;
        chk("rst_en", {31'd0, bus.fifo_rd_en}, 32'd0);
        @(posedge clk); #1;
        chk_quiet("midrst");
        rst = 1'b0; bus.pix_req = 1'b0;
        m_run = 0; m_errp = 0;
        idle(2);
        chk("sb_left", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
